// File: rtl/mux_n_pipe_pkg.sv
// Shared defaults and derived-width helpers for the pipelined N:1 channel mux.
package mux_n_pipe_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_N     = 16;

    function automatic int sel_width(input int n);
        return $clog2(n);
    endfunction

    // Channel count must split evenly into two power-of-two half banks
    function automatic bit n_is_legal(input int n);
        return (n >= 4) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/mux_n_pipe_bank.sv
// Combinational M:1 select of WIDTH-bit lanes; the top builds each half bank from one of these.
module mux_bank
    import mux_n_pipe_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int M     = DEF_N / 2,
    localparam int SW    = sel_width(M)
) (
    input  logic [M*WIDTH-1:0] din,
    input  logic [SW-1:0]      sel,
    output logic [WIDTH-1:0]   dout
);

    always_comb begin
        dout = '0;
        for (int k = 0; k < M; k++) begin
            if (sel == SW'(k)) begin
                dout = din[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// Two-stage valid/ready N:1 channel mux with external or round-robin channel select.
module mux_n_pipe
    import mux_n_pipe_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int N     = DEF_N,
    localparam int SELW  = sel_width(N)
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [N*WIDTH-1:0] IN,
    input  logic [SELW-1:0]    SEL,
    input  logic               RR_EN,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic [WIDTH-1:0]   OUT,
    output logic [SELW-1:0]    OUT_SEL,
    output logic               OUT_VALID,
    input  logic               OUT_READY
);

    localparam int HALF = N / 2;

    if (!n_is_legal(N)) begin : g_bad_n
        $error("mux_n_pipe: N must be a power of two and at least 4");
    end

    logic              en;
    logic              accept;
    logic [SELW-1:0]   rr_ptr;
    logic [SELW-1:0]   eff_sel;
    logic [WIDTH-1:0]  lo_bank;
    logic [WIDTH-1:0]  hi_bank;

    logic [WIDTH-1:0]  lo_p0;
    logic [WIDTH-1:0]  hi_p0;
    logic [SELW-1:0]   sel_p0;
    logic              vld_p0;
    logic              vld_p1;

    // Whole pipe moves together: it only stalls when the output beat is stuck
    assign en        = !vld_p1 || OUT_READY;
    assign IN_READY  = en;
    assign accept    = IN_VALID && en && RESET_N;
    assign eff_sel   = RR_EN ? rr_ptr : SEL;
    assign OUT_VALID = vld_p1;

    mux_bank #(.WIDTH(WIDTH), .M(HALF)) u_bank_lo (
        .din  (IN[HALF*WIDTH-1:0]),
        .sel  (eff_sel[SELW-2:0]),
        .dout (lo_bank)
    );

    mux_bank #(.WIDTH(WIDTH), .M(HALF)) u_bank_hi (
        .din  (IN[N*WIDTH-1:HALF*WIDTH]),
        .sel  (eff_sel[SELW-2:0]),
        .dout (hi_bank)
    );

    // Pointer wraps naturally at N because N is a power of two
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            rr_ptr <= '0;
        end else if (accept && RR_EN) begin
            rr_ptr <= rr_ptr + SELW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (en) begin
            vld_p0 <= IN_VALID;
            vld_p1 <= vld_p0;
        end
    end

    // Stage 1: both half-bank results plus the full select that chose them
    always_ff @(posedge CLK) begin
        if (accept) begin
            lo_p0  <= lo_bank;
            hi_p0  <= hi_bank;
            sel_p0 <= eff_sel;
        end
    end

    // Stage 2: select MSB picks the half; holds across bubbles and stalls
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            OUT     <= '0;
            OUT_SEL <= '0;
        end else if (en && vld_p0) begin
            OUT     <= sel_p0[SELW-1] ? hi_p0 : lo_p0;
            OUT_SEL <= sel_p0;
        end
    end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed plus randomized bench for mux_n_pipe with a queue-based reference model.
module tb_mux_n_pipe;

    localparam int W   = 16;
    localparam int NCH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [NCH*W-1:0] in_bus;
    logic [3:0]       sel;
    logic             rr_en, in_valid, in_ready;
    logic [W-1:0]     out;
    logic [3:0]       out_sel;
    logic             out_valid, out_ready;

    logic [31:0]      in2;
    logic [1:0]       sel2;
    logic             rr2, iv2, ir2, ov2, or2;
    logic [7:0]       out2;
    logic [1:0]       out_sel2;

    mux_n_pipe #(.WIDTH(W), .N(NCH)) dut (
        .CLK(clk), .RESET_N(rst_n), .IN(in_bus), .SEL(sel), .RR_EN(rr_en),
        .IN_VALID(in_valid), .IN_READY(in_ready), .OUT(out), .OUT_SEL(out_sel),
        .OUT_VALID(out_valid), .OUT_READY(out_ready)
    );

    mux_n_pipe #(.WIDTH(8), .N(4)) dut2 (
        .CLK(clk), .RESET_N(rst_n), .IN(in2), .SEL(sel2), .RR_EN(rr2),
        .IN_VALID(iv2), .IN_READY(ir2), .OUT(out2), .OUT_SEL(out_sel2),
        .OUT_VALID(ov2), .OUT_READY(or2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_bus();
        for (int k = 0; k < NCH * W / 32; k++) in_bus[k*32 +: 32] = $urandom;
    endtask

    // Reference model: expected beats in acceptance order, channel data taken at accept time
    logic [W-1:0] qd[$];
    logic [3:0]   qs[$];
    int           mptr = 0;
    bit           held = 0;
    logic [W-1:0] hold_d;
    logic [3:0]   hold_s;

    always @(negedge clk) begin
        logic [3:0] esel;
        if (!rst_n) begin
            qd.delete();
            qs.delete();
            mptr = 0;
            held = 0;
        end else begin
            chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (held) begin
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_out", 64'(out), 64'(hold_d));
                chk("hold_sel", 64'(out_sel), 64'(hold_s));
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 64'(qd.size() > 0), 64'(1));
                if (qd.size() > 0) begin
                    chk("sb_out", 64'(out), 64'(qd.pop_front()));
                    chk("sb_sel", 64'(out_sel), 64'(qs.pop_front()));
                end
            end
            held   = out_valid && !out_ready;
            hold_d = out;
            hold_s = out_sel;
            if (in_valid && in_ready) begin
                esel = rr_en ? 4'(mptr) : sel;
                qd.push_back(in_bus[esel*W +: W]);
                qs.push_back(esel);
                if (rr_en) mptr = (mptr + 1) % NCH;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] hd;
        logic [3:0]   hs;
        logic [31:0]  saved2;

        rst_n = 1'b0; in_bus = '0; sel = '0; rr_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in2 = '0; sel2 = '0; rr2 = 1'b0; iv2 = 1'b0; or2 = 1'b1;

        // Reset state, with a beat offered during reset that must never appear
        tick();
        in_valid = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out", 64'(out), 64'(0));
        chk("rst_out_sel", 64'(out_sel), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'(0));
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("rst_no_leak", 64'(out_valid), 64'(0));

        // Fixed select, latency
        for (int k = 0; k < NCH; k++) in_bus[k*W +: W] = 16'h1000 + 16'(k);
        sel = 4'hB;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_edge1_valid", 64'(out_valid), 64'(0));
        tick();
        chk("lat_edge2_valid", 64'(out_valid), 64'(1));
        chk("fixed_out", 64'(out), 64'(16'h100B));
        chk("fixed_sel", 64'(out_sel), 64'(4'hB));
        tick();
        chk("fixed_single", 64'(out_valid), 64'(0));

        // N=4, WIDTH=8 instance
        saved2 = $urandom;
        in2 = saved2; sel2 = 2'd3; iv2 = 1'b1;
        tick();
        iv2 = 1'b0;
        tick();
        chk("n4_valid", 64'(ov2), 64'(1));
        chk("n4_out_ch3", 64'(out2), 64'(saved2[31:24]));
        chk("n4_sel", 64'(out_sel2), 64'(3));
        saved2 = $urandom;
        in2 = saved2; sel2 = 2'd1; iv2 = 1'b1;
        tick();
        iv2 = 1'b0;
        tick();
        chk("n4_out_ch1", 64'(out2), 64'(saved2[15:8]));

        // Streaming: SEL 0..15 back to back, no bubbles
        for (int j = 0; j <= NCH; j++) begin
            in_valid = (j < NCH);
            sel = 4'(j);
            tick();
            if (j >= 1) begin
                chk("stream_valid", 64'(out_valid), 64'(1));
                chk("stream_out", 64'(out), 64'(16'h1000 + 16'(j - 1)));
            end
        end
        in_valid = 1'b0;
        tick();

        // Round-robin wrap over 18 beats; SEL is noise
        rr_en = 1'b1;
        for (int j = 0; j <= 18; j++) begin
            in_valid = (j < 18);
            sel = 4'($urandom);
            rand_bus();
            tick();
            if (j >= 1) begin
                chk("rr_valid", 64'(out_valid), 64'(1));
                chk("rr_sel", 64'(out_sel), 64'((j - 1) % NCH));
            end
        end
        in_valid = 1'b0;
        rr_en = 1'b0;
        tick();

        // Backpressure with a full pipe
        in_valid = 1'b1;
        rand_bus(); sel = 4'($urandom);
        tick();
        rand_bus(); sel = 4'($urandom);
        tick();
        out_ready = 1'b0;
        rand_bus(); sel = 4'($urandom);
        #1;
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        hd = out;
        hs = out_sel;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_stall_ready", 64'(in_ready), 64'(0));
            chk("bp_stall_out", 64'(out), 64'(hd));
            chk("bp_stall_sel", 64'(out_sel), 64'(hs));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        chk("bp_drained", 64'(qd.size()), 64'(0));

        // Random traffic, mode switches mid-stream
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            if (($urandom % 16) == 0) rr_en = ~rr_en;
            sel = 4'($urandom);
            rand_bus();
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        chk("rand_drained", 64'(qd.size()), 64'(0));

        // Reset with two beats in flight
        rr_en = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_bus();
        tick();
        rand_bus();
        tick();
        chk("mid_full_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_out", 64'(out), 64'(0));
        chk("mid_rst_ptr", 64'(dut.rr_ptr), 64'(0));
        rst_n = 1'b1;
        out_ready = 1'b1;
        sel = 4'h5;
        rand_bus();
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_next_valid", 64'(out_valid), 64'(1));
        chk("mid_next_sel", 64'(out_sel), 64'(0));
        tick();
        chk("mid_no_partial", 64'(out_valid), 64'(0));
        tick();
        chk("final_drained", 64'(qd.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
